spi_out_sched: RTL

- Round-robin scheduler that shares one pseudo-SPI output engine (SRAM-to-analog bit shifter) among NUM_REQ requesters, e.g. CPU core and the config loader.
- Latches the winning requester's start address and word count, then sequences the engine's active-low BGN: hold-in-reset, run, wait for done, release.
- Returns a one-cycle ACK to the winning requester.
- Sits between the requesters and the engine's BGN/ADDR_BGN/DATA_LEN/spi_is_done pins.

---
 rtl/spi_out_sched.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_out_sched.sv
// ---------------------------------------------------------------------------
// spi_out_sched
//
// Round-robin scheduler that shares one pseudo-SPI output engine among
// NUM_REQ requesters. The winner's start address and word count are latched
// and presented to the engine. The engine's active-low BGN is then sequenced
// through hold-in-reset (LOAD), run (RUN) and release (FIN). FIN returns a
// one-cycle ACK to the granted requester.
//
// Optional feature (macro SPI_OUT_SCHED_TIMEOUT_EN):
//   When it is defined, a TMO_W-bit counter bounds the RUN phase. If the
//   counter expires, the transfer ends with ERR pulsed alongside ACK.
//   When it is undefined, RUN waits for SPI_DONE indefinitely and ERR is 0.
//
// Ports:
//   CLK           system clock, all logic on posedge
//   RSTN          synchronous active-low reset
//   REQ           per-requester level request, held until ACK
//   REQ_ADDR      packed start addresses, requester i at [i*ADDR_W +: ADDR_W]
//   REQ_LEN       packed word counts, requester i at [i*LEN_W +: LEN_W]
//   ACK           one-cycle completion pulse to the granted requester
//   ERR           one-cycle timeout flag, coincident with ACK
//   BUSY          high whenever the scheduler is not idle
//   GNT_ID        index of the current or last granted requester
//   SPI_BGN       engine enable / active-low reset
//   SPI_ADDR_BGN  latched start address to the engine
//   SPI_DATA_LEN  latched word count to the engine
//   SPI_DONE      engine spi_is_done
// ---------------------------------------------------------------------------
module spi_out_sched #(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 10,
    parameter int LEN_W    = 8,
    parameter int LOAD_CYC = 2,
    parameter int TMO_W    = 16
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic [NUM_REQ-1:0]        REQ,
    input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
    input  logic [NUM_REQ*LEN_W-1:0]  REQ_LEN,
    output logic [NUM_REQ-1:0]        ACK,
    output logic                      ERR,
    output logic                      BUSY,
    output logic [2:0]                GNT_ID,
    output logic                      SPI_BGN,
    output logic [ADDR_W-1:0]         SPI_ADDR_BGN,
    output logic [LEN_W-1:0]          SPI_DATA_LEN,
    input  logic                      SPI_DONE
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || LOAD_CYC < 1 || TMO_W < 2 ||
        ADDR_W < 1 || LEN_W < 1) begin : g_param_check
        $error("spi_out_sched: parameter out of range");
    end

    localparam int         CNT_W    = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
    localparam logic [3:0] NR4      = 4'(NUM_REQ);
    localparam logic [2:0] LAST_ID  = 3'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FIN
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         rr_ptr;

    logic               found;
    logic [2:0]         win;
    logic [3:0]         pos;
    logic [ADDR_W-1:0]  addr_sel;
    logic [LEN_W-1:0]   len_sel;
    logic               grant;
    logic [2:0]         ack_id;

`ifdef SPI_OUT_SCHED_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    logic [TMO_W-1:0]   tmo;
    logic               tmo_hit;
`endif

    // Scan offsets 0..NUM_REQ-1 from rr_ptr. The first requester found wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        pos   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = {1'b0, rr_ptr} + 4'(i);
            if (pos >= NR4) begin
                pos = pos - NR4;
            end
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!found && pos == 4'(k) && REQ[k]) begin
                    found = 1'b1;
                    win   = 3'(k);
                end
            end
        end
    end

    always_comb begin
        addr_sel = '0;
        len_sel  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (win == 3'(k)) begin
                addr_sel = REQ_ADDR[k*ADDR_W +: ADDR_W];
                len_sel  = REQ_LEN[k*LEN_W +: LEN_W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
`ifdef SPI_OUT_SCHED_TIMEOUT_EN
        tmo_hit   = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                if (found) begin
                    grant     = 1'b1;
                    state_nxt = (len_sel == '0) ? S_FIN : S_LOAD;
                end
            end
            S_LOAD: begin
                if (cnt == '0) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (SPI_DONE) begin
                    state_nxt = S_FIN;
                end
`ifdef SPI_OUT_SCHED_TIMEOUT_EN
                // Expire on the edge where the counter would reach all-ones.
                else if (tmo == TMO_LAST) begin
                    state_nxt = S_FIN;
                    tmo_hit   = 1'b1;
                end
`endif
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // A zero-length grant enters FIN directly from IDLE, before GNT_ID is updated.
    assign ack_id = grant ? win : GNT_ID;

    // Outputs are registered from the next state, so they line up with the state.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            cnt          <= '0;
            rr_ptr       <= '0;
            ACK          <= '0;
            BUSY         <= 1'b0;
            GNT_ID       <= '0;
            SPI_BGN      <= 1'b0;
            SPI_ADDR_BGN <= '0;
            SPI_DATA_LEN <= '0;
        end else begin
            if (grant) begin
                SPI_ADDR_BGN <= addr_sel;
                SPI_DATA_LEN <= len_sel;
                GNT_ID       <= win;
                cnt          <= CNT_W'(LOAD_CYC - 1);
            end else if (state == S_LOAD && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            if (state == S_FIN) begin
                rr_ptr <= (GNT_ID == LAST_ID) ? 3'd0 : GNT_ID + 3'd1;
            end

            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                ACK[k] <= (state_nxt == S_FIN) && (ack_id == 3'(k));
            end

            BUSY    <= (state_nxt != S_IDLE);
            SPI_BGN <= (state_nxt == S_RUN);
        end
    end

`ifdef SPI_OUT_SCHED_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            tmo <= '0;
            ERR <= 1'b0;
        end else begin
            // The counter is held at zero outside RUN, so it starts from zero on entry.
            tmo <= (state == S_RUN) ? tmo + 1'b1 : '0;
            ERR <= tmo_hit;
        end
    end
`else
    assign ERR = 1'b0;
`endif

endmodule
